div32_seq: RTL and testbench

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_seq_if.sv | 24 ++
 rtl/div32_seq.sv | 185 ++++++++++++++++++
 tb/tb_div32_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div32_seq_if.sv
// Request/result bundle for the sequential 32-bit divider.
interface div32_seq_if;
  localparam int unsigned W = 32;

  logic         start;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_zero;

  modport master (
    output start, sign, a, b,
    input  busy, done, quo, rem, div_zero
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, quo, rem, div_zero
  );
endinterface

// File: rtl/div32_seq.sv
// Sequential 32-bit restoring divider, one quotient bit per cycle, MSB first.
// A started operation finishes 33 cycles later; a zero divisor finishes next cycle.
// Define DIV32_SIGNED_EN to honour the sign input (two's-complement, truncating
// toward zero); without it every operation is unsigned and no fix-up logic exists.
module div32_seq (
  input  logic        clk,
  input  logic        rst,
  div32_seq_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic          busy_q;
  logic          done_q;

  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  part_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic          dz_r;

  logic          start_acc;
  logic          b_zero;
  logic          last_iter;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          take;
  logic [W-1:0]  quo_step;
  logic [W-1:0]  rem_step;
  logic [W-1:0]  quo_res;
  logic [W-1:0]  rem_res;

`ifdef DIV32_SIGNED_EN
  logic          neg_q_q;
  logic          neg_r_q;
  logic          op_signed;
`endif

  assign start_acc = (state_q == IDLE) && bus.start;
  assign b_zero    = (bus.b == '0);
  assign last_iter = (cnt_q == CW'(W - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (start_acc) state_nxt = b_zero ? FIN : RUN;
      RUN:  if (last_iter) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      RUN:     busy_nxt = 1'b1;
      FIN:     done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Operand magnitudes presented to the unsigned core
  always_comb begin
`ifdef DIV32_SIGNED_EN
    op_signed = bus.sign;
    a_mag = (op_signed && bus.a[W-1]) ? W'(-bus.a) : bus.a;
    b_mag = (op_signed && bus.b[W-1]) ? W'(-bus.b) : bus.b;
`else
    a_mag = bus.a;
    b_mag = bus.b;
`endif
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    shifted  = {part_q, dvd_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    take     = ~trial[W];
    rem_step = take ? trial[W-1:0] : shifted[W-1:0];
    quo_step = {dvd_q[W-2:0], take};
  end

  // Result sign correction applied as the final step is written
  always_comb begin
`ifdef DIV32_SIGNED_EN
    quo_res = neg_q_q ? W'(-quo_step) : quo_step;
    rem_res = neg_r_q ? W'(-rem_step) : rem_step;
`else
    quo_res = quo_step;
    rem_res = rem_step;
`endif
  end

  // Iteration datapath: operand capture and per-cycle shift/subtract
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      part_q <= '0;
      cnt_q  <= '0;
    end else if (start_acc && !b_zero) begin
      dvd_q  <= a_mag;
      dvs_q  <= b_mag;
      part_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      dvd_q  <= quo_step;
      part_q <= rem_step;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

`ifdef DIV32_SIGNED_EN
  // Result sign flags captured with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start_acc && !b_zero) begin
      neg_q_q <= op_signed && (bus.a[W-1] ^ bus.b[W-1]);
      neg_r_q <= op_signed && bus.a[W-1];
    end
  end
`endif

  // Visible results update only when an operation completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= '0;
      rem_r <= '0;
      dz_r  <= 1'b0;
    end else if (start_acc && b_zero) begin
      quo_r <= '1;
      rem_r <= bus.a;
      dz_r  <= 1'b1;
    end else if ((state_q == RUN) && last_iter) begin
      quo_r <= quo_res;
      rem_r <= rem_res;
      dz_r  <= 1'b0;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.quo      = quo_r;
  assign bus.rem      = rem_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_div32_seq;

`ifdef DIV32_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  div32_seq_if bus ();

  div32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] eq;
  logic [31:0] er;
  logic        edz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (SIGNED_EN && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  function automatic logic [95:0] snap();
    return 96'({bus.busy, bus.done, bus.div_zero, bus.quo, bus.rem});
  endfunction

  function automatic logic [95:0] pack(input logic busy, input logic done, input logic dz,
                                       input logic [31:0] q, input logic [31:0] r);
    return 96'({busy, done, dz, q, r});
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check every cycle until one cycle after done
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] mq;
    logic [31:0] mr;
    logic        mdz;
    model(s, a, b, mq, mr, mdz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = s;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sign  = ~s;
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (b != 32'd0) begin
      for (int i = 1; i <= 32; i++) begin
        check("run_phase", snap(), pack(1'b1, 1'b0, edz, eq, er));
        if (inject && i == 4) begin
          @(negedge clk);
          bus.start = 1'b1;
          bus.sign  = 1'b0;
          bus.a     = 32'd9;
          bus.b     = 32'd3;
          @(posedge clk); #1;
          bus.start = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    eq  = mq;
    er  = mr;
    edz = mdz;
    check("done_cycle", snap(), pack(1'b0, 1'b1, edz, eq, er));
    @(posedge clk); #1;
    check("after_done", snap(), pack(1'b0, 1'b0, edz, eq, er));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          sel;

    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    eq = '0; er = '0; edz = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_state", snap(), pack(1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Basic unsigned case
    do_op(1'b0, 32'd100, 32'd7, 1'b0);
    check("u100_7_quo", 96'(bus.quo), 96'(32'd14));
    check("u100_7_rem", 96'(bus.rem), 96'(32'd2));

    // Negative dividend
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    if (SIGNED_EN) begin
      check("s_m100_7", 96'({bus.quo, bus.rem}), 96'({32'hFFFF_FFF2, 32'hFFFF_FFFE}));
    end else begin
      check("u_m100_7", 96'({bus.quo, bus.rem}), 96'({32'h2492_4916, 32'h0000_0002}));
    end

    // Divide by zero
    do_op(1'b0, 32'h1234_5678, 32'd0, 1'b0);
    check("dz_result", 96'({bus.div_zero, bus.quo, bus.rem}), 96'({1'b1, 32'hFFFF_FFFF, 32'h1234_5678}));

    // Signed overflow corner
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    if (SIGNED_EN)
      check("s_overflow", 96'({bus.div_zero, bus.quo, bus.rem}), 96'({1'b0, 32'h8000_0000, 32'd0}));

    // Start while busy must be ignored
    do_op(1'b0, 32'd1000, 32'd33, 1'b1);
    check("busy_ignored", 96'({bus.quo, bus.rem}), 96'({32'd30, 32'd10}));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_second_done", snap(), pack(1'b0, 1'b0, edz, eq, er));
    end

    // Start held during the done cycle is ignored, accepted in next IDLE cycle
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'hAAAA_0001; bus.b = 32'd0;
    @(posedge clk); #1;
    eq = 32'hFFFF_FFFF; er = 32'hAAAA_0001; edz = 1'b1;
    check("zero_done", snap(), pack(1'b0, 1'b1, 1'b1, eq, er));
    bus.a = 32'h5555_0002;
    @(posedge clk); #1;
    check("start_in_done_ignored", snap(), pack(1'b0, 1'b0, 1'b1, eq, er));
    @(posedge clk); #1;
    bus.start = 1'b0;
    er = 32'h5555_0002;
    check("start_in_idle_taken", snap(), pack(1'b0, 1'b1, 1'b1, eq, er));
    @(posedge clk); #1;

    // div_zero clears on the next normal completion
    do_op(1'b0, 32'd77, 32'd77, 1'b0);
    check("dz_cleared", 96'(bus.div_zero), 96'(1'b0));

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd5000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    eq = '0; er = '0; edz = 1'b0;
    check("async_reset", snap(), pack(1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", snap(), pack(1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
    end
    do_op(1'b0, 32'd5000, 32'd3, 1'b0);

    // Random operations
    for (int n = 0; n < 40; n++) begin
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15));
        4:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = 32'($urandom);
      endcase
      do_op(rs, ra, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
